// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack-access sequencer and the external stack-pointer block.
package stack_ctrl_pkg;

    localparam int unsigned OP_W = 2;
    localparam int unsigned SRC_W = 2;
    localparam int unsigned ST_W = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 2'b00;
    localparam logic [OP_W-1:0] OP_PUSH = 2'b01;
    localparam logic [OP_W-1:0] OP_POP  = 2'b10;
    localparam logic [OP_W-1:0] OP_PEEK = 2'b11;

    localparam logic [SRC_W-1:0] SP_HOLD = 2'b00;
    localparam logic [SRC_W-1:0] SP_INC  = 2'b01;
    localparam logic [SRC_W-1:0] SP_DEC  = 2'b10;

    localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] ST_PUSH_MEM = 3'd1;
    localparam logic [ST_W-1:0] ST_SP_INC   = 3'd2;
    localparam logic [ST_W-1:0] ST_SP_DEC   = 3'd3;
    localparam logic [ST_W-1:0] ST_RD_MEM   = 3'd4;
    localparam logic [ST_W-1:0] ST_RESP     = 3'd5;

    function automatic logic st_mem_req(input logic [ST_W-1:0] st);
        return (st == ST_PUSH_MEM) || (st == ST_RD_MEM);
    endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Push/pop/peek sequencer: issues the data-memory access and steps the external stack pointer.
// Every output is registered from the next state so it is glitch-free toward memory and the pointer block.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter logic [DATA_W-1:0] SP_BASE  = DATA_W'(16'h0000),
    parameter logic [DATA_W-1:0] SP_LIMIT = DATA_W'(16'h00FF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              err_overflow,
    output logic              err_underflow,
    input  logic              err_clear,
    input  logic [DATA_W-1:0] spCur,
    output logic [1:0]        spSrc,
    output logic              spWrite,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [ST_W-1:0]   r_state;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_err_overflow;
    logic              r_err_underflow;
    logic [1:0]        r_sp_src;
    logic              r_sp_write;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [ST_W-1:0]   w_state_nxt;
    logic              w_rsp_err_nxt;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;
    logic [DATA_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic [DATA_W-1:0] w_sp_minus1;

    // Modulo arithmetic; only issued when the stack is non-empty.
    assign w_sp_minus1 = spCur - DATA_W'(1);

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_ovf_set       = 1'b0;
        w_unf_set       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (spCur == SP_LIMIT) begin
                                w_state_nxt   = ST_RESP;
                                w_rsp_err_nxt = 1'b1;
                                w_ovf_set     = 1'b1;
                            end else begin
                                w_state_nxt     = ST_PUSH_MEM;
                                w_mem_addr_nxt  = spCur;
                                w_mem_wdata_nxt = cmd_wdata;
                            end
                        end
                        OP_POP: begin
                            if (spCur == SP_BASE) begin
                                w_state_nxt   = ST_RESP;
                                w_rsp_err_nxt = 1'b1;
                                w_unf_set     = 1'b1;
                            end else begin
                                w_state_nxt = ST_SP_DEC;
                            end
                        end
                        OP_PEEK: begin
                            if (spCur == SP_BASE) begin
                                w_state_nxt   = ST_RESP;
                                w_rsp_err_nxt = 1'b1;
                                w_unf_set     = 1'b1;
                            end else begin
                                w_state_nxt    = ST_RD_MEM;
                                w_mem_addr_nxt = w_sp_minus1;
                            end
                        end
                        default: w_state_nxt = ST_RESP;
                    endcase
                end
            end
            ST_PUSH_MEM: if (mem_ack) w_state_nxt = ST_SP_INC;
            ST_SP_INC:   w_state_nxt = ST_RESP;
            ST_SP_DEC: begin
                // The pointer block decrements on this same edge, so spCur-1 is the updated value.
                w_state_nxt    = ST_RD_MEM;
                w_mem_addr_nxt = w_sp_minus1;
            end
            ST_RD_MEM: begin
                if (mem_ack) begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_rdata_nxt = mem_rdata;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; sticky error set has priority over clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_cmd_ready     <= 1'b1;
            r_rsp_valid     <= 1'b0;
            r_rsp_err       <= 1'b0;
            r_rsp_rdata     <= '0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
            r_sp_src        <= SP_HOLD;
            r_sp_write      <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_cmd_ready     <= (w_state_nxt == ST_IDLE);
            r_rsp_valid     <= (w_state_nxt == ST_RESP);
            r_rsp_err       <= w_rsp_err_nxt;
            r_rsp_rdata     <= w_rsp_rdata_nxt;
            r_err_overflow  <= w_ovf_set | (r_err_overflow & ~err_clear);
            r_err_underflow <= w_unf_set | (r_err_underflow & ~err_clear);
            r_sp_src        <= (w_state_nxt == ST_SP_INC) ? SP_INC :
                               (w_state_nxt == ST_SP_DEC) ? SP_DEC : SP_HOLD;
            r_sp_write      <= (w_state_nxt == ST_SP_INC) || (w_state_nxt == ST_SP_DEC);
            r_mem_req       <= st_mem_req(w_state_nxt);
            r_mem_we        <= (w_state_nxt == ST_PUSH_MEM);
            r_mem_addr      <= w_mem_addr_nxt;
            r_mem_wdata     <= w_mem_wdata_nxt;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_err       = r_rsp_err;
    assign rsp_rdata     = r_rsp_rdata;
    assign err_overflow  = r_err_overflow;
    assign err_underflow = r_err_underflow;
    assign spSrc         = r_sp_src;
    assign spWrite       = r_sp_write;
    assign mem_req       = r_mem_req;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: pointer-block and memory models, stack-as-queue reference model.
module tb_stack_ctrl;
    import stack_ctrl_pkg::*;

    localparam logic [15:0] SP_BASE  = 16'h0000;
    localparam logic [15:0] SP_LIMIT = 16'h00FF;
    localparam int          DEPTH    = 255;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_wdata = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        err_overflow;
    logic        err_underflow;
    logic        err_clear = 1'b0;
    logic [15:0] spCur;
    logic [1:0]  spSrc;
    logic        spWrite;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0;

    int n_checks = 0;
    int n_pass = 0;

    logic [15:0] stk[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    logic [15:0] mem_arr [0:255];
    int          ack_wait = 0;
    int          wait_cnt = 0;

    stack_ctrl #(.DATA_W(16), .SP_BASE(SP_BASE), .SP_LIMIT(SP_LIMIT)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clear(err_clear),
        .spCur(spCur), .spSrc(spSrc), .spWrite(spWrite),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Stack-pointer register block
    always @(posedge clock or posedge reset) begin
        if (reset) spCur <= SP_BASE;
        else if (spWrite) begin
            if (spSrc == 2'b01) spCur <= spCur + 16'd1;
            else if (spSrc == 2'b10) spCur <= spCur - 16'd1;
        end
    end

    // Memory: ack after ack_wait request cycles, read data valid with ack
    always @(negedge clock) begin
        mem_ack   = mem_req && !reset && (wait_cnt >= ack_wait);
        mem_rdata = mem_arr[mem_addr[7:0]];
    end

    always @(posedge clock or posedge reset) begin
        if (reset) wait_cnt <= 0;
        else if (mem_req && mem_ack) begin
            wait_cnt <= 0;
            if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
        end else if (mem_req) wait_cnt <= wait_cnt + 1;
    end

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Issue one command and check latency, memory/pointer activity and result against the model.
    task automatic do_cmd(input logic [1:0] op, input logic [15:0] wd, input int wt, input logic clr);
        int exp_lat, lat, n_req, n_spw, exp_spw;
        logic exp_err, exp_mem, chk_data, seen_req, unstable, bad_ready, bad_src;
        logic [15:0] exp_addr, exp_data, seen_addr, seen_wdata;
        logic [1:0] exp_src, seen_src;
        logic seen_we;
        exp_err = 0; exp_mem = 0; chk_data = 0; exp_addr = 0; exp_data = 0;
        exp_spw = 0; exp_src = 2'b00; exp_lat = 1;
        ack_wait = wt;
        if (clr) begin m_ovf = 0; m_unf = 0; end
        case (op)
            OP_PUSH: if (stk.size() == DEPTH) begin exp_err = 1; m_ovf = 1; end
                     else begin
                         exp_mem = 1; exp_addr = SP_BASE + 16'(stk.size());
                         stk.push_back(wd); exp_lat = 3 + wt; exp_spw = 1; exp_src = 2'b01;
                     end
            OP_POP:  if (stk.size() == 0) begin exp_err = 1; m_unf = 1; end
                     else begin
                         exp_mem = 1; exp_addr = SP_BASE + 16'(stk.size() - 1);
                         exp_data = stk.pop_back(); chk_data = 1;
                         exp_lat = 3 + wt; exp_spw = 1; exp_src = 2'b10;
                     end
            OP_PEEK: if (stk.size() == 0) begin exp_err = 1; m_unf = 1; end
                     else begin
                         exp_mem = 1; exp_addr = SP_BASE + 16'(stk.size() - 1);
                         exp_data = stk[stk.size() - 1]; chk_data = 1; exp_lat = 2 + wt;
                     end
            default: ;
        endcase

        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd; err_clear = clr;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0; cmd_op = 2'b00; err_clear = 1'b0;

        lat = 0; n_req = 0; n_spw = 0; seen_req = 0; unstable = 0; bad_ready = 0; bad_src = 0;
        seen_addr = 0; seen_wdata = 0; seen_we = 0; seen_src = 2'b00;
        while (lat < 64) begin
            @(negedge clock);
            lat++;
            if (cmd_ready !== 1'b0) bad_ready = 1;
            if (spWrite) begin n_spw++; seen_src = spSrc; end
            else if (spSrc !== 2'b00) bad_src = 1;
            if (mem_req) begin
                n_req++;
                if (!seen_req) begin
                    seen_req = 1; seen_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata;
                end else if (mem_addr !== seen_addr || mem_we !== seen_we || mem_wdata !== seen_wdata)
                    unstable = 1;
            end
            if (rsp_valid) break;
        end

        n_checks++;
        if (rsp_valid !== 1'b1) $display("FAIL op%0d timeout: rsp_valid=%b after %0d cycles", op, rsp_valid, lat);
        else n_pass++;
        n_checks++;
        if (lat !== exp_lat) $display("FAIL op%0d latency: got %0d want %0d", op, lat, exp_lat);
        else n_pass++;
        n_checks++;
        if (rsp_err !== exp_err) $display("FAIL op%0d rsp_err: got %b want %b", op, rsp_err, exp_err);
        else n_pass++;
        n_checks++;
        if (n_req !== (exp_mem ? 1 + wt : 0)) $display("FAIL op%0d mem_req cycles: got %0d want %0d", op, n_req, exp_mem ? 1 + wt : 0);
        else n_pass++;
        if (exp_mem) begin
            n_checks++;
            if (seen_addr !== exp_addr || seen_we !== (op == OP_PUSH))
                $display("FAIL op%0d mem addr/we: got %h/%b want %h/%b", op, seen_addr, seen_we, exp_addr, op == OP_PUSH);
            else n_pass++;
            n_checks++;
            if (unstable !== 1'b0) $display("FAIL op%0d mem stability: unstable=%b want 0", op, unstable);
            else n_pass++;
        end
        if (op == OP_PUSH && exp_mem) begin
            n_checks++;
            if (seen_wdata !== wd) $display("FAIL push wdata: got %h want %h", seen_wdata, wd);
            else n_pass++;
        end
        n_checks++;
        if (n_spw !== exp_spw || (exp_spw == 1 && seen_src !== exp_src))
            $display("FAIL op%0d spWrite: got %0d cycles src %b want %0d src %b", op, n_spw, seen_src, exp_spw, exp_src);
        else n_pass++;
        n_checks++;
        if (bad_src !== 1'b0 || bad_ready !== 1'b0)
            $display("FAIL op%0d idle spSrc/cmd_ready: bad_src=%b bad_ready=%b want 0/0", op, bad_src, bad_ready);
        else n_pass++;
        if (chk_data) begin
            n_checks++;
            if (rsp_rdata !== exp_data) $display("FAIL op%0d rdata: got %h want %h", op, rsp_rdata, exp_data);
            else n_pass++;
        end
        n_checks++;
        if (spCur !== SP_BASE + 16'(stk.size())) $display("FAIL op%0d spCur: got %h want %h", op, spCur, SP_BASE + 16'(stk.size()));
        else n_pass++;
        n_checks++;
        if ({err_overflow, err_underflow} !== {m_ovf, m_unf})
            $display("FAIL op%0d sticky flags: got ovf=%b unf=%b want %b %b", op, err_overflow, err_underflow, m_ovf, m_unf);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL op%0d back to idle: rsp_valid=%b cmd_ready=%b want 0/1", op, rsp_valid, cmd_ready);
        else n_pass++;
    endtask

    task automatic do_clear();
        @(negedge clock);
        err_clear = 1'b1;
        @(posedge clock);
        #1;
        err_clear = 1'b0;
        m_ovf = 0; m_unf = 0;
        n_checks++;
        if ({err_overflow, err_underflow} !== 2'b00)
            $display("FAIL err_clear: got ovf=%b unf=%b want 0 0", err_overflow, err_underflow);
        else n_pass++;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_err, err_overflow, err_underflow, spSrc, spWrite, mem_req, mem_we} !== 10'b10_0000_0000)
            $display("FAIL reset ctrl: got rdy=%b rv=%b re=%b ov=%b un=%b src=%b sw=%b req=%b we=%b want 1 and rest 0",
                     cmd_ready, rsp_valid, rsp_err, err_overflow, err_underflow, spSrc, spWrite, mem_req, mem_we);
        else n_pass++;
        n_checks++;
        if ({rsp_rdata, mem_addr, mem_wdata} !== 48'h0)
            $display("FAIL reset data: got rdata=%h addr=%h wdata=%h want 0", rsp_rdata, mem_addr, mem_wdata);
        else n_pass++;
        n_checks++;
        if (spCur !== SP_BASE) $display("FAIL reset spCur: got %h want %h", spCur, SP_BASE);
        else n_pass++;
    endtask

    task automatic test_push_pop_peek();
        apply_reset();
        do_cmd(OP_PUSH, 16'hBEEF, 0, 0);
        apply_reset();
        do_cmd(OP_PUSH, 16'h1111, 0, 0);
        do_cmd(OP_PUSH, 16'h2222, 0, 0);
        do_cmd(OP_POP, 16'h0, 0, 0);
        do_cmd(OP_PEEK, 16'h0, 0, 0);
        do_cmd(OP_NOP, 16'h0, 0, 0);
    endtask

    task automatic test_underflow();
        apply_reset();
        do_cmd(OP_POP, 16'h0, 0, 0);
        do_clear();
        do_cmd(OP_PEEK, 16'h0, 0, 0);
        do_cmd(OP_POP, 16'h0, 0, 1);
        do_clear();
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) do_cmd(OP_PUSH, 16'($urandom), 0, 0);
        do_cmd(OP_PUSH, 16'h5A5A, 0, 0);
        do_cmd(OP_PEEK, 16'h0, 1, 0);
        do_cmd(OP_POP, 16'h0, 0, 0);
        do_cmd(OP_PUSH, 16'hC0DE, 0, 1);
        do_cmd(OP_PUSH, 16'h0BAD, 0, 0);
    endtask

    task automatic test_mem_wait();
        apply_reset();
        do_cmd(OP_PUSH, 16'h1234, 3, 0);
        do_cmd(OP_PUSH, 16'h5678, 2, 0);
        do_cmd(OP_POP, 16'h0, 3, 0);
        do_cmd(OP_PEEK, 16'h0, 4, 0);
    endtask

    task automatic test_reset_mid();
        logic saw_rsp;
        apply_reset();
        do_cmd(OP_PUSH, 16'hA5A5, 0, 0);
        ack_wait = 5;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = OP_PEEK;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0; cmd_op = 2'b00;
        @(negedge clock);
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0) $display("FAIL mid-reset setup: req=%b we=%b want 1/0", mem_req, mem_we);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || cmd_ready !== 1'b1 || spCur !== SP_BASE)
            $display("FAIL mid-reset: req=%b rdy=%b spCur=%h want 0/1/%h", mem_req, cmd_ready, spCur, SP_BASE);
        else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        stk.delete(); m_ovf = 0; m_unf = 0;
        saw_rsp = 0;
        repeat (8) begin
            @(negedge clock);
            if (rsp_valid || mem_req) saw_rsp = 1;
        end
        n_checks++;
        if (saw_rsp !== 1'b0) $display("FAIL mid-reset leftover activity: got %b want 0", saw_rsp);
        else n_pass++;
        do_cmd(OP_POP, 16'h0, 0, 0);
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            do_cmd(2'($urandom_range(0, 3)), 16'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                   1'($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_push_pop_peek();
        test_underflow();
        test_overflow();
        test_mem_wait();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Stack-access sequencer directly upstream of the stack-pointer register block.
- Accepts push/pop/peek commands from the control unit and issues the data-memory transaction.
- Drives the pointer block's source select (spSrc) and write enable (spWrite), and reads back its current value (spCur).
- Checks overflow/underflow, so the pointer is only ever stepped by ±1 inside [SP_BASE, SP_LIMIT].

Parameters:
- DATA_W, 16: data and address width; must match the pointer width.
- SP_BASE, 16'h0000: empty-stack pointer value; equals the pointer register's reset value.
- SP_LIMIT, 16'h00FF: full-stack pointer value; a push at this value is rejected.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; returns the FSM to IDLE.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on a clock edge where cmd_valid & cmd_ready.
- cmd_op  in  2  00 nop, 01 push, 10 pop, 11 peek.
- cmd_wdata  in  DATA_W  push data, sampled at accept.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  DATA_W  pop/peek data; valid with rsp_valid and held until the next response.
- rsp_err  out  1  qualifies rsp_valid: command rejected.
- err_overflow  out  1  sticky; set on a rejected push.
- err_underflow  out  1  sticky; set on a rejected pop or peek.
- err_clear  in  1  synchronous clear of both sticky flags.
- spCur  in  DATA_W  current stack pointer.
- spSrc  out  2  00 hold, 01 +1, 10 −1; never 11.
- spWrite  out  1  pointer write enable.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_W  word address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  transaction complete; read data valid in the same cycle.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset values: FSM=IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, err flags=0, spSrc=00, spWrite=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-operation: mem_req drops immediately and any in-flight command is discarded. The pointer block resets to SP_BASE concurrently.
- FSM states: IDLE, PUSH_MEM, SP_INC, SP_DEC, RD_MEM, RESP.
- IDLE:
  - Accept push: if spCur==SP_LIMIT, go to RESP with rsp_err=1 and set err_overflow; otherwise latch cmd_wdata and go to PUSH_MEM.
  - Accept pop: if spCur==SP_BASE, go to RESP with err and set err_underflow; otherwise go to SP_DEC.
  - Accept peek: same underflow check as pop; otherwise go to RD_MEM with the address latched as spCur−1.
  - Accept nop: go to RESP, no error.
- PUSH_MEM: mem_req=1, mem_we=1, mem_addr=spCur, mem_wdata=latched data. On mem_ack go to SP_INC.
- SP_INC: spWrite=1, spSrc=01 for exactly one cycle; then go to RESP.
- SP_DEC: spWrite=1, spSrc=10 for exactly one cycle; then go to RD_MEM with the address taken as the updated spCur (sampled in RD_MEM).
- RD_MEM: mem_req=1, mem_we=0. On mem_ack, capture mem_rdata into rsp_rdata and go to RESP.
- RESP: rsp_valid=1 for one cycle; then go to IDLE.
- mem_req, mem_addr, mem_we and mem_wdata stay stable while waiting for mem_ack; mem_ack is ignored outside PUSH_MEM/RD_MEM.
- Latency with zero-wait memory (ack in the first request cycle), counted from the accept edge:
  - Push: rsp_valid in cycle 3.
  - Pop: rsp_valid in cycle 3.
  - Peek: rsp_valid in cycle 2.
  - Rejected command or nop: rsp_valid in cycle 1.
  - Each memory wait cycle adds 1.
- spWrite is high in SP_INC/SP_DEC only; spSrc is 00 in every other state.
- err_clear and a new error in the same cycle: set wins.
- Pointer arithmetic is done in the pointer block. The limit checks guarantee no wrap past SP_BASE/SP_LIMIT.
- Peek address spCur−1 is computed modulo 2^DATA_W, but is only issued when spCur≠SP_BASE.

Decomposition:
- Shared package/include:
  - cmd_op encodings: OP_NOP, OP_PUSH, OP_POP, OP_PEEK.
  - spSrc encodings: SP_HOLD=00, SP_INC=01, SP_DEC=10, shared with the pointer block.
  - FSM state encodings.
- Single flat module; no sub-module. The pointer register block stays external and is instantiated alongside in the datapath top.

Test Plan:
- Reset, then push 16'hBEEF with zero-wait memory → write to addr 0x0000 in cycle 1; spWrite/spSrc=01 in cycle 2; rsp_valid in cycle 3 with rsp_err=0; spCur becomes 0x0001.
- Push 0x1111, then push 0x2222, then pop → read at 0x0001, rsp_rdata=0x2222, spCur=0x0001. Then peek → read at 0x0000, rsp_rdata=0x1111, spCur unchanged.
- Pop at SP_BASE → no mem_req, no spWrite; rsp_valid with rsp_err=1 in cycle 1; err_underflow=1. Then err_clear → flag returns to 0.
- Fill to SP_LIMIT=0x00FF, then push → rejected, err_overflow=1, spCur stays 0x00FF.
- mem_ack delayed 3 cycles on a push → mem_req/addr/wdata stable for 4 cycles; cmd_ready=0 throughout; rsp_valid in cycle 6.
- Assert reset while in RD_MEM → mem_req=0 and cmd_ready=1 immediately; spCur=SP_BASE; no rsp_valid.
